// File: rtl/manchester_rx_ctrl_pkg.sv
// Shared definitions for the Manchester receive-path controller:
// link-state encodings, default sizing and the GPIO bit map seen by firmware.
package manchester_rx_ctrl_pkg;

   localparam int WORD_W          = 12;
   localparam int DEF_DEPTH       = 8;
   localparam int DEF_TIMEOUT_CYC = 78000;  // 1 ms at 78 MHz

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2,
      ST_LOST   = 2'd3
   } link_state_e;

   // gpioin bit positions (controller -> CPU)
   localparam int GPIN_WORD_LSB = 0;
   localparam int GPIN_WORD_MSB = 11;
   localparam int GPIN_VALID    = 12;
   localparam int GPIN_OVERFLOW = 13;
   localparam int GPIN_LOST     = 14;

   // gpioout bit positions (CPU -> controller)
   localparam int GPOUT_ENABLE  = 0;
   localparam int GPOUT_ACK     = 1;
   localparam int GPOUT_FLUSH   = 2;

endpackage

// File: rtl/rx_word_fifo.sv
// Synchronous word FIFO with a registered head word. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module rx_word_fifo
   import manchester_rx_ctrl_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WORD_W-1:0]        din,
   output logic [WORD_W-1:0]        head,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]       fill_q, fill_d;
   logic [WORD_W-1:0] head_q, head_d;
   logic              full, do_push, do_pop;

   assign full    = (fill_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && (fill_q != '0) && !flush;
   assign do_push = push && !flush && (!full || do_pop);
   assign drop    = push && !flush && full && !do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d   = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
         endcase
      end
      // Head looks through this cycle's write so push-into-empty and
      // push+pop-when-full both present the right word next cycle.
      head_d = flush ? '0 : mem_d[rd_ptr_d];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         head_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         head_q   <= head_d;
      end
   end

   assign head = head_q;
   assign fill = fill_q;

endmodule

// File: rtl/manchester_rx_ctrl.sv
// Receive-path controller: synchronises decoder strobes, queues words for
// firmware (toggle-ack pop) and tracks link state with a silence watchdog.
module manchester_rx_ctrl
   import manchester_rx_ctrl_pkg::*;
#(
   parameter int DEPTH       = DEF_DEPTH,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                     CLK,
   input  logic                     reset_n,
   input  logic [WORD_W-1:0]        dec_data,
   input  logic                     dec_front,
   input  logic                     dec_not_work,
   input  logic                     rx_enable,
   input  logic                     cpu_ack,
   input  logic                     cpu_flush,
   output logic [WORD_W-1:0]        word_out,
   output logic                     word_valid,
   output logic                     overflow,
   output logic                     link_lost,
   output logic [1:0]               link_state,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int              WDW    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WDW-1:0]  WD_MAX = WDW'(TIMEOUT_CYC);

   logic [2:0]     front_sync_q, front_sync_d;
   logic [1:0]     nw_sync_q, nw_sync_d;
   logic           edge_q, edge_d;
   logic           ack_q, ack_d;
   logic           overflow_q, overflow_d;
   logic           link_lost_q, link_lost_d;
   logic [WDW-1:0] wd_q, wd_d;
   link_state_e    state_q, state_d;
   logic           nw_s, acc, drop;

   // Two sync flops, a third for edge detect; the edge is registered so
   // acc lands two cycles after the strobe is first sampled.
   assign front_sync_d = {front_sync_q[1:0], dec_front};
   assign nw_sync_d    = {nw_sync_q[0], dec_not_work};
   assign edge_d       = front_sync_q[1] & ~front_sync_q[2];
   assign ack_d        = cpu_ack;
   assign nw_s         = nw_sync_q[1];
   assign acc          = edge_q && rx_enable && !cpu_flush && (state_q != ST_IDLE);

   always_comb begin
      state_d = state_q;
      if (!rx_enable)     state_d = ST_IDLE;
      else if (cpu_flush) state_d = ST_HUNT;
      else begin
         case (state_q)
            ST_IDLE:   state_d = ST_HUNT;
            ST_HUNT:   if (nw_s || wd_q == WD_MAX) state_d = ST_LOST;
                       else if (acc)               state_d = ST_LOCKED;
            ST_LOCKED: if (nw_s || wd_q == WD_MAX) state_d = ST_LOST;
            ST_LOST:   if (acc && !nw_s)           state_d = ST_LOCKED;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      wd_d = wd_q;
      if (state_d == ST_IDLE || acc || (state_d == ST_HUNT && state_q != ST_HUNT))
         wd_d = '0;
      else if ((state_q == ST_HUNT || state_q == ST_LOCKED) && wd_q != WD_MAX)
         wd_d = wd_q + 1'b1;
   end

   assign overflow_d  = !cpu_flush && (overflow_q || drop);
   assign link_lost_d = !cpu_flush && (link_lost_q || state_d == ST_LOST);

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         front_sync_q <= '0;
         nw_sync_q    <= '0;
         edge_q       <= 1'b0;
         ack_q        <= 1'b0;
         overflow_q   <= 1'b0;
         link_lost_q  <= 1'b0;
         wd_q         <= '0;
         state_q      <= ST_IDLE;
      end else begin
         front_sync_q <= front_sync_d;
         nw_sync_q    <= nw_sync_d;
         edge_q       <= edge_d;
         ack_q        <= ack_d;
         overflow_q   <= overflow_d;
         link_lost_q  <= link_lost_d;
         wd_q         <= wd_d;
         state_q      <= state_d;
      end
   end

   // A toggle seen while empty is absorbed inside the FIFO.
   rx_word_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (CLK),
      .rst_n (reset_n),
      .push  (acc),
      .pop   (cpu_ack != ack_q),
      .flush (cpu_flush),
      .din   (dec_data),
      .head  (word_out),
      .fill  (fill),
      .drop  (drop)
   );

   assign word_valid = (fill != '0);
   assign overflow   = overflow_q;
   assign link_lost  = link_lost_q;
   assign link_state = state_q;

endmodule
